pc_flag_unit: RTL and testbench
===============================

# pc_flag_unit

Program-counter and condition-flag stage that sits directly downstream of the ALU in the single-cycle 16-bit datapath. It latches the N/V/Z flags the ALU produces according to the opcode in flight, evaluates the 3-bit branch condition of B/BR against the latched flags, and registers the next PC. It also supplies PC+2 for PCS and owns the RUN/HALT state machine that freezes the machine on HLT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  instruction at current pc: [15:12] opcode, [11:9] ccc, [8:0] B offset
- flags_in  in  3  ALU flags {N,V,Z} for the current instruction
- reg_rs  in  16  register-file read of rs, the BR target
- stall  in  1  hold all state this cycle; no PC, flag or state update
- pc  out  16  current PC, registered
- pc_plus2  out  16  pc + 2, combinational; PCS write data and fall-through address
- flags  out  3  latched {N,V,Z}, registered
- branch_taken  out  1  current instruction is B/BR and its condition holds, combinational
- halted  out  1  high in HALT state, registered

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0011, SLL 0100, SRA 0101, ROR 0110, B 1100, BR 1101, HLT 1111; all others are non-flag, non-control.
- Flag write enable, applied only in RUN with stall low:
  - ADD, SUB: write N, V and Z from flags_in.
  - XOR, SLL, SRA, ROR: write Z only; N and V hold.
  - All other opcodes: flags hold.
- Conditions on latched flags (ccc):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 always
- Branch targets:
  - B target: pc_plus2 + (sign-extended instr[8:0] << 1), 16-bit modular, no overflow detection.
  - BR target: reg_rs, used unmodified.
- next_pc: target if branch_taken, else pc_plus2. pc_plus2 wraps 16'hFFFE -> 16'h0000.
- FSM states: RUN, HALT.
  - RUN -> HALT when opcode is HLT and stall is low. pc does not advance, so it stays at the HLT address.
  - HALT is absorbing: pc, flags and state hold, and only rst exits.
  - While halted, branch_taken is forced to 0.
- Branch decisions use the flags latched before the current instruction. flags_in of the current instruction never affects its own branch.

## Timing
- Reset values: pc = RESET_PC, flags = 3'b000, state = RUN, halted = 0.
- rst has priority over stall and over HLT.
- Reset mid-HALT returns to RUN with pc = RESET_PC on the next edge.
- Latency: pc, flags and halted update one edge after the instruction is presented. branch_taken and pc_plus2 are zero-latency combinational.
- stall high: every register holds and the HLT transition is deferred; branch_taken is still driven.
- Back-to-back: a flag-setting instruction at edge k is visible to the branch evaluated in cycle k+1.

## Structure
- Shared package holds the opcode constants, ccc encodings, RUN/HALT state encoding and flag bit indices (N=2, V=1, Z=0). These are the same bit positions the ALU flag output uses.
- Both adders (PC+2 and the B target) are instances of the existing CLA_add_16; their overflow outputs are left unused.
- One combinational sub-module, cond_eval (ccc, flags -> take), sits beside the registers. It is verified standalone against the 8-row condition list.

## Test plan
- Reset: assert rst 1 cycle -> pc=0000, flags=000, halted=0. Then NOPs (opcode 1000) for 3 cycles -> pc 0002, 0004, 0006, flags unchanged.
- SUB with flags_in=001 (Z), then B ccc=001 offset 9'h004 at pc=0010 -> flags=001, branch_taken=1, next pc=001A.
- Partial update: ADD with flags_in=110, then XOR with flags_in=001 -> flags=111 after the XOR edge. Then B ccc=110 -> taken. B ccc=010 -> not taken, pc+2.
- BR ccc=111 reg_rs=1234 -> pc=1234. B offset 9'h1FF at pc=0000 -> pc=0000; sign extension and wrap verified.
- HLT at pc=0040 -> halted=1 next edge, pc holds at 0040 for 10 cycles under random instr/flags_in. Then rst -> pc=0000, halted=0.
- Stall: hold stall with ADD/flags_in=100 and HLT each for 2 cycles -> pc, flags and halted unchanged until stall drops, then normal updates.

Source files
------------

// File: rtl/pc_flag_unit_pkg.sv
// Shared encodings for the PC/flag stage: opcodes, branch conditions, FSM states, flag bit positions.
// Flag bit indices match the ALU flag output ordering {N,V,Z}.
package pc_flag_unit_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OVF = 3'b110,
        CC_AL  = 3'b111
    } ccc_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/CLA_add_16.sv
// 16-bit adder: 4-bit groups with group lookahead between groups, ripple inside a group.
// Signed overflow is carry-in xor carry-out of the MSB.
module CLA_add_16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_ovf
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [16:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int grp = 0; grp < 4; grp++) begin
            for (int k = 0; k < 3; k++) begin
                w_c[grp*4+k+1] = w_g[grp*4+k] | (w_p[grp*4+k] & w_c[grp*4+k]);
            end
            // Group carry-out skips the in-group ripple.
            w_c[grp*4+4] = w_g[grp*4+3]
                         | (w_p[grp*4+3] & w_g[grp*4+2])
                         | (w_p[grp*4+3] & w_p[grp*4+2] & w_g[grp*4+1])
                         | (w_p[grp*4+3] & w_p[grp*4+2] & w_p[grp*4+1] & w_g[grp*4])
                         | (&w_p[grp*4 +: 4] & w_c[grp*4]);
        end
    end

    assign o_sum = w_p ^ w_c[15:0];
    assign o_ovf = w_c[16] ^ w_c[15];

endmodule

// File: rtl/pc_flag_unit_cond_eval.sv
// Branch condition evaluator: 3-bit ccc against latched {N,V,Z}, purely combinational.
module cond_eval
    import pc_flag_unit_pkg::*;
(
    input  logic [2:0] i_ccc,
    input  logic [2:0] i_flags,
    output logic       o_take
);
    logic w_n;
    logic w_v;
    logic w_z;

    assign w_n = i_flags[FLAG_N];
    assign w_v = i_flags[FLAG_V];
    assign w_z = i_flags[FLAG_Z];

    always_comb begin
        o_take = 1'b0;
        case (ccc_e'(i_ccc))
            CC_NE:   o_take = !w_z;
            CC_EQ:   o_take = w_z;
            CC_GT:   o_take = !w_z && !w_n;
            CC_LT:   o_take = w_n;
            CC_GTE:  o_take = w_z || !w_n;
            CC_LTE:  o_take = w_n || w_z;
            CC_OVF:  o_take = w_v;
            CC_AL:   o_take = 1'b1;
            default: o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// PC / condition-flag stage behind the ALU: latches flags per opcode, resolves B/BR, registers next PC.
// RUN/HALT FSM freezes everything on HLT until reset; stall holds all state.
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_instr,
    input  logic [2:0]  i_flags_in,
    input  logic [15:0] i_reg_rs,
    input  logic        i_stall,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus2,
    output logic [2:0]  o_flags,
    output logic        o_branch_taken,
    output logic        o_halted
);
    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_pc;
    logic [2:0]  r_flags;

    logic [3:0]  w_opcode;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_b_offset;
    logic [15:0] w_b_target;
    logic [15:0] w_next_pc;
    logic        w_take;
    logic        w_is_branch;
    logic        w_pc_we;
    logic        w_wr_nv;
    logic        w_wr_z;
    logic        w_pc_ovf_unused;
    logic        w_tgt_ovf_unused;

    assign w_opcode   = i_instr[15:12];
    assign w_b_offset = {{6{i_instr[8]}}, i_instr[8:0], 1'b0};

    CLA_add_16 u_pc_inc (
        .i_a   (r_pc),
        .i_b   (16'd2),
        .i_cin (1'b0),
        .o_sum (w_pc_plus2),
        .o_ovf (w_pc_ovf_unused)
    );

    CLA_add_16 u_b_tgt (
        .i_a   (w_pc_plus2),
        .i_b   (w_b_offset),
        .i_cin (1'b0),
        .o_sum (w_b_target),
        .o_ovf (w_tgt_ovf_unused)
    );

    // Condition sees only flags latched by earlier instructions, never this cycle's flags_in.
    cond_eval u_cond (
        .i_ccc   (i_instr[11:9]),
        .i_flags (r_flags),
        .o_take  (w_take)
    );

    assign w_is_branch    = (w_opcode == OP_B) || (w_opcode == OP_BR);
    assign o_branch_taken = w_is_branch && w_take && (r_state == ST_RUN);
    assign w_next_pc      = !o_branch_taken      ? w_pc_plus2 :
                            (w_opcode == OP_BR)  ? i_reg_rs   : w_b_target;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_wr_nv     = 1'b0;
        w_wr_z      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!i_stall) begin
                    if (w_opcode == OP_HLT) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_we = 1'b1;
                        case (w_opcode)
                            OP_ADD, OP_SUB: begin
                                w_wr_nv = 1'b1;
                                w_wr_z  = 1'b1;
                            end
                            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_wr_z = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_we) r_pc <= w_next_pc;
            if (w_wr_nv) begin
                r_flags[FLAG_N] <= i_flags_in[FLAG_N];
                r_flags[FLAG_V] <= i_flags_in[FLAG_V];
            end
            if (w_wr_z) r_flags[FLAG_Z] <= i_flags_in[FLAG_Z];
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus2 = w_pc_plus2;
    assign o_flags    = r_flags;
    assign o_halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_flag_unit.sv
// Randomised and directed bench for pc_flag_unit against an instruction-level reference model.
module tb_pc_flag_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h8000;
    logic [2:0]  flags_in = 3'b000;
    logic [15:0] reg_rs = 16'h0000;
    logic        stall = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [2:0]  flags;
    logic        branch_taken;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference state: architectural PC, flags {N,V,Z}, halted.
    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    bit          m_halted;

    pc_flag_unit #(.RESET_PC(16'h0000)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_instr        (instr),
        .i_flags_in     (flags_in),
        .i_reg_rs       (reg_rs),
        .i_stall        (stall),
        .o_pc           (pc),
        .o_pc_plus2     (pc_plus2),
        .o_flags        (flags),
        .o_branch_taken (branch_taken),
        .o_halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic bit cond_holds(input logic [2:0] ccc, input logic [2:0] f);
        bit n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit exp_taken();
        int op;
        op = int'(instr[15:12]);
        if (m_halted) return 1'b0;
        if (op != 12 && op != 13) return 1'b0;
        return cond_holds(instr[11:9], m_flags);
    endfunction

    function automatic logic [15:0] exp_next_pc();
        int off;
        off = int'(instr[8:0]);
        if (off >= 256) off = off - 512;
        if (!exp_taken()) return 16'(int'(m_pc) + 2);
        if (instr[15:12] == 4'd13) return reg_rs;
        return 16'(int'(m_pc) + 2 + off * 2);
    endfunction

    function automatic void model_step();
        int op;
        logic [15:0] npc;
        op  = int'(instr[15:12]);
        npc = exp_next_pc();
        if (rst) begin
            m_pc = 16'h0000; m_flags = 3'b000; m_halted = 1'b0;
        end else if (!stall && !m_halted) begin
            if (op == 15) begin
                m_halted = 1'b1;
            end else begin
                m_pc = npc;
                if (op == 0 || op == 1) m_flags = flags_in;
                else if (op == 3 || op == 4 || op == 5 || op == 6) m_flags[0] = flags_in[0];
            end
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("flags", {13'd0, flags}, {13'd0, m_flags});
            check("halted", {15'd0, halted}, {15'd0, m_halted});
            check("pc_plus2", pc_plus2, 16'(int'(m_pc) + 2));
            check("branch_taken", {15'd0, branch_taken}, {15'd0, exp_taken()});
        end
    end

    task automatic apply(input logic [15:0] i, input logic [2:0] f, input logic [15:0] rs,
                         input logic st, input logic r);
        instr = i; flags_in = f; reg_rs = rs; stall = st; rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input logic [15:0] i, input logic [2:0] f, input logic [15:0] rs,
                       input logic st, input logic r);
        apply(i, f, rs, st, r);
        tick();
    endtask

    initial begin
        m_pc = 'x; m_flags = 'x; m_halted = 1'b0;
        // Reset and NOP fall-through
        run(16'h8000, 3'b111, 16'h0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_pc", pc, 16'h0000);
        check("rst_flags", {13'd0, flags}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        run(16'h8000, 3'b111, 16'h0, 1'b0, 1'b0);
        check("nop1_pc", pc, 16'h0002);
        run(16'h8000, 3'b111, 16'h0, 1'b0, 1'b0);
        check("nop2_pc", pc, 16'h0004);
        run(16'h8000, 3'b111, 16'h0, 1'b0, 1'b0);
        check("nop3_pc", pc, 16'h0006);
        check("nop_flags", {13'd0, flags}, 16'h0000);
        for (int k = 0; k < 4; k++) run(16'h8000, 3'b000, 16'h0, 1'b0, 1'b0);
        // SUB sets Z, then B EQ +4 from 0x0010
        run(16'h1000, 3'b001, 16'h0, 1'b0, 1'b0);
        check("sub_pc", pc, 16'h0010);
        check("sub_flags", {13'd0, flags}, 16'h0001);
        apply(16'hC204, 3'b000, 16'h0, 1'b0, 1'b0);
        #1 check("beq_taken", {15'd0, branch_taken}, 16'h0001);
        tick();
        check("beq_pc", pc, 16'h001A);
        // Partial flag update
        run(16'h0000, 3'b110, 16'h0, 1'b0, 1'b0);
        run(16'h3000, 3'b001, 16'h0, 1'b0, 1'b0);
        check("xor_flags", {13'd0, flags}, 16'h0007);
        apply(16'hCC00, 3'b000, 16'h0, 1'b0, 1'b0);
        #1 check("bovf_taken", {15'd0, branch_taken}, 16'h0001);
        tick();
        apply(16'hC404, 3'b000, 16'h0, 1'b0, 1'b0);
        #1 check("bgt_not_taken", {15'd0, branch_taken}, 16'h0000);
        tick();
        check("bgt_pc", pc, 16'h0022);
        // BR, then sign extension / wrap
        run(16'hDE00, 3'b000, 16'h1234, 1'b0, 1'b0);
        check("br_pc", pc, 16'h1234);
        run(16'h8000, 3'b000, 16'h0, 1'b0, 1'b1);
        run(16'hCFFF, 3'b000, 16'h0, 1'b0, 1'b0);
        check("bneg_pc", pc, 16'h0000);
        run(16'hDE00, 3'b000, 16'hFFFE, 1'b0, 1'b0);
        check("pc_plus2_wrap", pc_plus2, 16'h0000);
        run(16'h8000, 3'b000, 16'h0, 1'b0, 1'b0);
        check("wrap_pc", pc, 16'h0000);
        // HLT at 0x0040
        run(16'hDE00, 3'b000, 16'h0040, 1'b0, 1'b0);
        run(16'hF000, 3'b000, 16'h0, 1'b0, 1'b0);
        check("hlt_halted", {15'd0, halted}, 16'h0001);
        check("hlt_pc", pc, 16'h0040);
        for (int k = 0; k < 10; k++)
            run(16'($urandom), 3'($urandom), 16'($urandom), 1'b0, 1'b0);
        check("halt_hold_pc", pc, 16'h0040);
        apply(16'hCE00, 3'b000, 16'h0, 1'b0, 1'b0);
        #1 check("halt_no_branch", {15'd0, branch_taken}, 16'h0000);
        tick();
        run(16'h8000, 3'b000, 16'h0, 1'b1, 1'b1);
        check("unhalt_pc", pc, 16'h0000);
        check("unhalt_halted", {15'd0, halted}, 16'h0000);
        // Stall holds state and defers HLT
        run(16'h0000, 3'b100, 16'h0, 1'b1, 1'b0);
        run(16'h0000, 3'b100, 16'h0, 1'b1, 1'b0);
        check("stall_pc", pc, 16'h0000);
        check("stall_flags", {13'd0, flags}, 16'h0000);
        run(16'h0000, 3'b100, 16'h0, 1'b0, 1'b0);
        check("unstall_flags", {13'd0, flags}, 16'h0004);
        check("unstall_pc", pc, 16'h0002);
        run(16'hF000, 3'b000, 16'h0, 1'b1, 1'b0);
        run(16'hF000, 3'b000, 16'h0, 1'b1, 1'b0);
        check("stall_hlt", {15'd0, halted}, 16'h0000);
        run(16'hF000, 3'b000, 16'h0, 1'b0, 1'b0);
        check("hlt_after_stall", {15'd0, halted}, 16'h0001);
        check("hlt_after_stall_pc", pc, 16'h0002);
        run(16'h8000, 3'b000, 16'h0, 1'b0, 1'b1);
        // Random phase
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] ri;
            logic        rr;
            ri = 16'($urandom);
            if (ri[15:12] == 4'hF && $urandom_range(0, 3) != 0) ri[15:12] = 4'h8;
            rr = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 150) == 0);
            run(ri, 3'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), rr);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
